axis_frame_len_mon: RTL and testbench
=====================================

AXIS_FRAME_LEN_MON -- requirements
Module: axis_frame_len_mon

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 64, monitored tdata width in bits.
REQ-002 SHALL have parameter KEEP_ENABLE, (DATA_WIDTH>8), tkeep honoured when 1.
REQ-003 SHALL have parameter KEEP_WIDTH, (DATA_WIDTH/8), tkeep width.
REQ-004 SHALL have parameter LEN_WIDTH, 16, byte-length field width.
REQ-005 SHALL have parameter MAX_LEN, 1518, oversize threshold in bytes.
REQ-006 SHALL have parameter FIFO_DEPTH, 4, status FIFO entries, power of two, at least 2.
REQ-007 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port monitor_axis_tkeep  input  KEEP_WIDTH  byte enables of monitored beat.
REQ-010 SHALL have ports monitor_axis_tvalid, monitor_axis_tready, monitor_axis_tlast  input  1 each  monitored handshake and end of frame.
REQ-011 SHALL have port status_len  output  LEN_WIDTH  byte length of head status entry.
REQ-012 SHALL have ports status_oversize, status_saturated  output  1 each  flags of head entry.
REQ-013 SHALL have ports status_valid output 1, status_ready input 1: status stream handshake.
REQ-014 SHALL have port stats_clear  input  1  synchronous statistics clear pulse.
REQ-015 SHALL have ports stat_frame_count output 32, stat_min_len and stat_max_len output LEN_WIDTH each, stat_drop_count output 16.
REQ-016 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-017 Beat SHALL be counted only when tvalid && tready; monitor never drives the bus.
REQ-018 Beat bytes SHALL be popcount(tkeep) when KEEP_ENABLE=1, else KEEP_WIDTH; tkeep=0 beat adds 0 bytes.
REQ-019 Accumulator SHALL add beat bytes each beat; on tlast beat final length = accumulator + beat bytes, accumulator returns to 0 the same edge.
REQ-020 Arithmetic SHALL saturate at 2^LEN_WIDTH-1; saturated flag set for that frame, cleared at frame end.
REQ-021 Oversize flag SHALL be set when final length > MAX_LEN (saturated implies oversize).
REQ-022 busy SHALL go high the cycle after a non-tlast beat, low the cycle after a tlast beat.
REQ-023 Frame end SHALL push {len, oversize, saturated} into status FIFO; status_valid high the cycle after the tlast beat (latency 1).
REQ-024 Status entry SHALL pop when status_valid && status_ready; outputs hold stable while status_valid && !status_ready.
REQ-025 Push and pop in the same cycle at full SHALL both succeed, no drop.
REQ-026 Push to full FIFO without pop SHALL drop the entry and increment stat_drop_count, saturating at 65535; stats still updated.
REQ-027 Every frame end SHALL increment stat_frame_count (wraps at 2^32) and update stat_min_len/stat_max_len, visible the cycle after the tlast beat.
REQ-028 stats_clear SHALL set frame_count=0, drop_count=0, min_len=all-ones, max_len=0; accumulator and FIFO unaffected.
REQ-029 stats_clear coincident with frame end SHALL clear first, then record that frame (frame_count=1, min=max=its length).
REQ-030 Single-beat frame (tlast on first beat) SHALL report that beat's bytes.

Reset
REQ-031 rst high SHALL asynchronously clear accumulator, flags, busy, FIFO pointers, status_valid=0, status_len=0, status flags=0.
REQ-032 rst SHALL set stat_frame_count=0, stat_drop_count=0, stat_min_len=all-ones, stat_max_len=0.
REQ-033 Reset mid-frame SHALL discard partial length; the first frame after deassertion counts only beats after reset.
REQ-034 No beat SHALL be counted in a cycle where rst is high.

Verification
REQ-035 DATA_WIDTH=8: reset, then 3 beats with tready=1, tlast on third -> status_len=3, flags 0, frame_count=1.
REQ-036 DATA_WIDTH=8: 1 beat without tlast, rst pulse, then 1 tlast beat -> status_len=1, never 2.
REQ-037 DATA_WIDTH=64: beats tkeep 0xFF,0xFF,0x0F last -> status_len=20; tvalid=1,tready=0 cycles add nothing.
REQ-038 MAX_LEN=16, DATA_WIDTH=64: 3 full beats -> status_len=24, status_oversize=1; LEN_WIDTH=4 -> status_len=15, saturated=1.
REQ-039 FIFO_DEPTH=4, status_ready=0: 6 single-beat frames -> 4 entries kept, stat_drop_count=2, frame_count=6.
REQ-040 Frames of 5 then 2 bytes, stats_clear with tlast of a 9-byte frame -> frame_count=1, min=max=9, drop_count=0.

Source files
------------

// File: rtl/axis_frame_len_mon.sv
// Passive AXI-Stream frame length monitor: measures byte length per frame, queues
// {len, oversize, saturated} status entries and keeps running frame statistics.
module axis_frame_len_mon #(
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int LEN_WIDTH   = 16,
    parameter int MAX_LEN     = 1518,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
    input  logic                  monitor_axis_tvalid,
    input  logic                  monitor_axis_tready,
    input  logic                  monitor_axis_tlast,
    output logic [LEN_WIDTH-1:0]  status_len,
    output logic                  status_oversize,
    output logic                  status_saturated,
    output logic                  status_valid,
    input  logic                  status_ready,
    input  logic                  stats_clear,
    output logic [31:0]           stat_frame_count,
    output logic [LEN_WIDTH-1:0]  stat_min_len,
    output logic [LEN_WIDTH-1:0]  stat_max_len,
    output logic [15:0]           stat_drop_count,
    output logic                  busy
);

    localparam int CntW = $clog2(KEEP_WIDTH + 1);
    localparam int SumW = ((LEN_WIDTH > CntW) ? LEN_WIDTH : CntW) + 1;
    localparam int PtrW = $clog2(FIFO_DEPTH);
    localparam int EntW = LEN_WIDTH + 2;
    localparam logic [SumW-1:0] LenMax = SumW'({LEN_WIDTH{1'b1}});
    localparam logic [PtrW:0]   FifoFull = (PtrW + 1)'(FIFO_DEPTH);

    logic [LEN_WIDTH-1:0] acc_q, acc_d;
    logic                 sat_q, sat_d;
    logic                 busy_q, busy_d;
    logic [PtrW:0]        wr_ptr_q, rd_ptr_q;
    logic [EntW-1:0]      mem_q [FIFO_DEPTH];
    logic [31:0]          frame_cnt_q, frame_cnt_d;
    logic [LEN_WIDTH-1:0] min_q, min_d, max_q, max_d;
    logic [15:0]          drop_q, drop_d;

    logic                 beat, frame_end, fifo_full, fifo_empty, pop, push, drop;
    logic [CntW-1:0]      beat_bytes;
    logic [SumW-1:0]      sum;
    logic                 sum_ovf, frame_sat, frame_ov;
    logic [LEN_WIDTH-1:0] frame_len;
    logic [EntW-1:0]      head;

    assign beat      = monitor_axis_tvalid && monitor_axis_tready;
    assign frame_end = beat && monitor_axis_tlast;

    always_comb begin
        beat_bytes = '0;
        if (KEEP_ENABLE != 0) begin
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                beat_bytes = beat_bytes + CntW'(monitor_axis_tkeep[i]);
            end
        end else begin
            beat_bytes = CntW'(KEEP_WIDTH);
        end
    end

    // Once saturated the accumulator sits at all-ones, so the flag stays sticky.
    assign sum       = SumW'(acc_q) + SumW'(beat_bytes);
    assign sum_ovf   = sum > LenMax;
    assign frame_len = sum_ovf ? {LEN_WIDTH{1'b1}} : sum[LEN_WIDTH-1:0];
    assign frame_sat = sat_q || sum_ovf;
    assign frame_ov  = frame_sat || (64'(frame_len) > 64'(MAX_LEN));

    always_comb begin
        acc_d  = acc_q;
        sat_d  = sat_q;
        busy_d = busy_q;
        if (beat) begin
            if (monitor_axis_tlast) begin
                acc_d  = '0;
                sat_d  = 1'b0;
                busy_d = 1'b0;
            end else begin
                acc_d  = frame_len;
                sat_d  = frame_sat;
                busy_d = 1'b1;
            end
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == FifoFull);
    assign pop        = !fifo_empty && status_ready;
    assign push       = frame_end && (!fifo_full || pop);
    assign drop       = frame_end && fifo_full && !pop;

    assign head             = mem_q[rd_ptr_q[PtrW-1:0]];
    assign status_valid     = !fifo_empty;
    assign status_len       = status_valid ? head[EntW-1:2] : '0;
    assign status_oversize  = status_valid && head[1];
    assign status_saturated = status_valid && head[0];

    // Clear acts first so a coincident frame end is recorded into fresh statistics.
    always_comb begin
        frame_cnt_d = stats_clear ? 32'd0 : frame_cnt_q;
        min_d       = stats_clear ? {LEN_WIDTH{1'b1}} : min_q;
        max_d       = stats_clear ? '0 : max_q;
        drop_d      = stats_clear ? 16'd0 : drop_q;
        if (frame_end) begin
            frame_cnt_d = frame_cnt_d + 32'd1;
            if (frame_len < min_d) min_d = frame_len;
            if (frame_len > max_d) max_d = frame_len;
        end
        if (drop && drop_d != 16'hFFFF) drop_d = drop_d + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            min_q       <= {LEN_WIDTH{1'b1}};
            max_q       <= '0;
            drop_q      <= '0;
        end else begin
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            min_q       <= min_d;
            max_q       <= max_d;
            drop_q      <= drop_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= {frame_len, frame_ov, frame_sat};
    end

    assign busy             = busy_q;
    assign stat_frame_count = frame_cnt_q;
    assign stat_min_len     = min_q;
    assign stat_max_len     = max_q;
    assign stat_drop_count  = drop_q;

endmodule

// File: tb/tb_axis_frame_len_mon.sv
// Randomized bench for axis_frame_len_mon against a frame-level reference model.
module tb_axis_frame_len_mon;

    localparam int KW = 8;
    localparam int LW = 8;
    localparam int ML = 100;
    localparam int FD = 4;
    localparam int LenSat = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic [KW-1:0] tkeep;
    logic          tvalid, tready, tlast;
    logic [LW-1:0] status_len;
    logic          status_oversize, status_saturated, status_valid;
    logic          status_ready, stats_clear;
    logic [31:0]   stat_frame_count;
    logic [LW-1:0] stat_min_len, stat_max_len;
    logic [15:0]   stat_drop_count;
    logic          busy;

    axis_frame_len_mon #(
        .DATA_WIDTH (64),
        .KEEP_ENABLE(1),
        .KEEP_WIDTH (KW),
        .LEN_WIDTH  (LW),
        .MAX_LEN    (ML),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .monitor_axis_tkeep (tkeep),
        .monitor_axis_tvalid(tvalid),
        .monitor_axis_tready(tready),
        .monitor_axis_tlast (tlast),
        .status_len         (status_len),
        .status_oversize    (status_oversize),
        .status_saturated   (status_saturated),
        .status_valid       (status_valid),
        .status_ready       (status_ready),
        .stats_clear        (stats_clear),
        .stat_frame_count   (stat_frame_count),
        .stat_min_len       (stat_min_len),
        .stat_max_len       (stat_max_len),
        .stat_drop_count    (stat_drop_count),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        bit ov;
        bit sat;
    } entry_t;

    entry_t q[$];
    int     m_bytes;
    bit     m_busy;
    longint m_frames;
    int     m_min, m_max, m_drops;
    int     n_checks = 0;
    int     n_pass = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_bytes  = 0;
        m_busy   = 1'b0;
        q.delete();
        m_frames = 0;
        m_min    = LenSat;
        m_max    = 0;
        m_drops  = 0;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".valid"}, status_valid, q.size() != 0);
        if (q.size() != 0) begin
            check({ctx, ".len"}, status_len, q[0].len);
            check({ctx, ".ov"}, status_oversize, q[0].ov);
            check({ctx, ".sat"}, status_saturated, q[0].sat);
        end else begin
            check({ctx, ".len_idle"}, status_len, 0);
        end
        check({ctx, ".busy"}, busy, m_busy);
        check({ctx, ".frames"}, stat_frame_count, m_frames & 64'hFFFF_FFFF);
        check({ctx, ".min"}, stat_min_len, m_min);
        check({ctx, ".max"}, stat_max_len, m_max);
        check({ctx, ".drops"}, stat_drop_count, m_drops);
    endtask

    // One clock: drive inputs, advance model on the edge, compare just after it.
    task automatic cycle(input bit v, input bit r, input bit l, input logic [KW-1:0] k,
                         input bit sr, input bit clr, input string ctx);
        entry_t e;
        tvalid = v; tready = r; tlast = l; tkeep = k;
        status_ready = sr; stats_clear = clr;
        @(posedge clk);
        if (clr) begin
            m_frames = 0; m_drops = 0; m_min = LenSat; m_max = 0;
        end
        if (sr && q.size() != 0) void'(q.pop_front());
        if (v && r) begin
            m_bytes += $countones(k);
            if (l) begin
                e.len = (m_bytes > LenSat) ? LenSat : m_bytes;
                e.sat = m_bytes > LenSat;
                e.ov  = m_bytes > ML;
                if (q.size() < FD) q.push_back(e);
                else if (m_drops < 65535) m_drops++;
                m_frames++;
                if (e.len < m_min) m_min = e.len;
                if (e.len > m_max) m_max = e.len;
                m_bytes = 0;
                m_busy  = 1'b0;
            end else begin
                m_busy = 1'b1;
            end
        end
        #1;
        check_all(ctx);
    endtask

    task automatic drain();
        repeat (FD + 1) cycle(0, 0, 0, '0, 1, 0, "drain");
    endtask

    // Reset held across an edge with a beat on the bus; that beat must not count.
    task automatic rst_pulse();
        rst = 1'b1;
        tvalid = 1'b1; tready = 1'b1; tlast = 1'b0; tkeep = '1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tvalid = 0; tready = 0; tlast = 0; tkeep = '0;
        status_ready = 0; stats_clear = 0;
        rst_pulse();

        // 8 + stall + 8 + 4 bytes = 20
        cycle(1, 1, 0, 8'hFF, 0, 0, "k20.b0");
        cycle(1, 0, 0, 8'hFF, 0, 0, "k20.stall");
        cycle(1, 1, 0, 8'hFF, 0, 0, "k20.b1");
        cycle(1, 1, 1, 8'h0F, 0, 0, "k20.last");
        check("k20.len", status_len, 20);
        drain();

        cycle(1, 1, 1, 8'h00, 1, 0, "empty_beat");
        cycle(1, 1, 1, 8'h07, 1, 0, "single_beat");

        // Mid-frame reset discards the partial length
        cycle(1, 1, 0, 8'hFF, 1, 0, "mid.b0");
        rst_pulse();
        cycle(1, 1, 1, 8'h01, 0, 0, "mid.last");
        check("mid.len", status_len, 1);
        drain();

        // 41 full beats = 328 bytes: saturates the 8-bit length
        repeat (40) cycle(1, 1, 0, 8'hFF, 1, 0, "sat.body");
        cycle(1, 1, 1, 8'hFF, 0, 0, "sat.last");
        check("sat.len", status_len, LenSat);
        check("sat.flag", status_saturated, 1);
        check("sat.ov", status_oversize, 1);
        cycle(1, 1, 1, 8'h03, 1, 0, "sat.after");
        drain();

        // FIFO overflow: six frames into four slots, then push+pop at full
        cycle(0, 0, 0, '0, 0, 1, "fifo.clr");
        for (int i = 0; i < 6; i++) cycle(1, 1, 1, 8'h01, 0, 0, "fifo.push");
        check("fifo.drops", stat_drop_count, 2);
        check("fifo.frames", stat_frame_count, 6);
        cycle(1, 1, 1, 8'h03, 1, 0, "fifo.pushpop");
        check("fifo.drops_hold", stat_drop_count, 2);
        drain();

        // Clear coincident with the end of a 9-byte frame
        cycle(1, 1, 1, 8'h1F, 1, 0, "clr.f5");
        cycle(1, 1, 1, 8'h03, 1, 0, "clr.f2");
        cycle(1, 1, 0, 8'hFF, 1, 0, "clr.f9a");
        cycle(1, 1, 1, 8'h01, 1, 1, "clr.f9b");
        check("clr.frames", stat_frame_count, 1);
        check("clr.min", stat_min_len, 9);
        check("clr.max", stat_max_len, 9);
        check("clr.drops", stat_drop_count, 0);

        // Random traffic: short frames, then long frames that reach oversize
        for (int i = 0; i < 3000; i++) begin
            logic [KW-1:0] k;
            k = ($urandom_range(0, 7) == 0) ? 8'h00 : KW'($urandom);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  (i < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 29) == 0),
                  k, $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
